conv_window_gen: RTL
====================

# conv_window_gen

Streaming 3x3 window generator that feeds the convolution core's 9-element window bus. It accepts a raster-order pixel stream, keeps the two previous rows in line buffers, and emits one complete 3x3 window per accepted pixel once the pixel completes a valid (unpadded) window position. It sits between the feature-map input stage and `conv2d_core`; `win_out` connects directly to that core's `input_window`.

## Interface
- `DATA_WIDTH`, 8: pixel width in bits; matches the conv core.
- `IMG_WIDTH`, 32: pixels per row; must be at least 3.
- `IMG_HEIGHT`, 32: rows per frame; must be at least 3.
- `clk`  in  1: single clock; all logic is rising-edge.
- `rst`  in  1: reset, synchronous, active-high.
- `pix_in`  in  DATA_WIDTH: input pixel, raster order, row-major.
- `pix_valid`  in  1: `pix_in` is valid.
- `pix_ready`  out  1: the block accepts `pix_in` this cycle.
- `win_out[0:8]`  out  DATA_WIDTH each: 3x3 window, row-major. [0] is the top-left (oldest row, oldest column). [8] is the bottom-right (the just-accepted pixel).
- `win_valid`  out  1: `win_out` holds a valid window.
- `win_ready`  in  1: the downstream block takes the window.
- `frame_done`  out  1: one-cycle pulse after the last pixel of a frame is accepted.

## Operation
- Accept condition: `pix_valid && pix_ready`.
- `pix_ready = !win_valid || win_ready`. This is a one-deep output register, so there are no combinational paths from `pix_valid` to any output.
- Counters:
  - `col` runs 0..IMG_WIDTH-1. `row` runs 0..IMG_HEIGHT-1. Both have width `$clog2` of their limit.
  - On accept, `col` increments. At IMG_WIDTH-1, `col` wraps to 0 and `row` increments.
  - At the last pixel of the frame (`row`=IMG_HEIGHT-1, `col`=IMG_WIDTH-1), both wrap to 0 and `frame_done` is set.
- Line buffers:
  - `lb_a` holds row r-1 and `lb_b` holds row r-2, each IMG_WIDTH deep, indexed by `col`.
  - On accept, each buffer is read before it is written. The new column is {`lb_b[col]`, `lb_a[col]`, `pix_in`}.
  - Then `lb_b[col]` <= old `lb_a[col]`, and `lb_a[col]` <= `pix_in`.
- Window register:
  - The 3x3 register shifts one column left on each accept. The new column enters at indices 2/5/8 (top/mid/bottom).
  - Columns left over from the previous row are present while `col` < 2; gating excludes them.
- Window emit condition: on accept with `row` >= 2 and `col` >= 2, `win_valid` <= 1 and `win_out` <= the updated window.
- Clearing `win_valid`: if `win_valid && win_ready` and no new window is emitted that cycle, `win_valid` <= 0.
- If a window is taken and a new one is emitted in the same cycle, `win_valid` stays 1 and `win_out` takes the new data.
- Output count: (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows per frame, in raster order of the bottom-right position.
- Data is passed through unchanged. There is no arithmetic; signedness is interpreted by the consumer.

## Timing
- Reset values: `win_valid`=0, `frame_done`=0, `win_out`=all zeros, `col`=`row`=0, and `pix_ready`=1 from the first cycle after reset.
- Line-buffer contents are not cleared. Row gating guarantees that stale data is never emitted.
- Latency: a pixel accepted in cycle N that completes a window gives `win_valid`=1 in cycle N+1.
- Throughput: 1 pixel/cycle while `win_ready` is held high.
- While `win_valid && !win_ready`, `win_out` and `win_valid` are held stable and `pix_ready`=0.
- `frame_done` is high in cycle N+1 after the last pixel is accepted in cycle N. It coincides with the final window's `win_valid` rise and lasts exactly one cycle, independent of `win_ready`.
- Reset mid-frame: the next accepted pixel is treated as (0,0) of a new frame, and any pending window is dropped.
- `pix_valid` low: no state changes except clearing `win_valid` on a downstream take.

## Configuration
- Macro: `CONV_WINDOW_STRIDE2_EN`.
- Defined: a window is emitted only when both `row` and `col` of the bottom-right pixel are even (and >= 2).
  - This gives floor((IMG_WIDTH-1)/2)*floor((IMG_HEIGHT-1)/2) windows per frame.
  - Line buffering and the pixel handshake are unchanged.
- Undefined: stride-1 behaviour exactly as in Operation.

## Structure
- Shared package `conv_pkg`:
  - `WIN_SIZE`=9.
  - The default `DATA_WIDTH`.
  - typedef `pix_t` (logic [DATA_WIDTH-1:0]).
  - typedef `win_t` (`pix_t` [0:WIN_SIZE-1]).
  - `conv2d_core` will import the same package.
- Sub-module `line_buffer`:
  - One IMG_WIDTH-deep, DATA_WIDTH-wide array with synchronous read-before-write at one address.
  - Instantiated twice (`lb_a`, `lb_b`).

## Test plan
- 4x4 frame, pixels 0..15, `win_ready`=1 -> 4 windows:
  - First: {0,1,2,4,5,6,8,9,10}.
  - Last: {5,6,7,9,10,11,13,14,15}.
  - `frame_done` pulses with the last window.
- Same frame with `win_ready` low for 3 cycles after the first window -> `pix_ready`=0, `win_out` held at {0,1,2,4,5,6,8,9,10}, and no window lost or duplicated.
- Two back-to-back 4x4 frames (0..15, then 100..115) -> the second frame's first window is {100,101,102,104,105,106,108,109,110}, with no data from frame 1.
- `rst` asserted after 7 pixels, then a full 4x4 frame (0..15) -> exactly 4 correct windows and no `win_valid` before pixel 10 of the new frame.
- `pix_valid` toggled every other cycle on a 4x4 frame -> the same 4 windows in order, each `win_valid` one cycle after its completing pixel.
- `CONV_WINDOW_STRIDE2_EN`, 5x5 frame, pixels 0..24 -> windows only at (2,2), (2,4), (4,2) and (4,4). The first is {0,1,2,5,6,7,10,11,12}.

Source files
------------

// File: rtl/conv_pkg.sv
// conv_pkg: types shared by the window generator and conv2d_core.
package conv_pkg;

  localparam int unsigned WIN_SIZE           = 9;
  localparam int unsigned DEFAULT_DATA_WIDTH = 8;

  typedef logic [DEFAULT_DATA_WIDTH-1:0] pix_t;
  typedef pix_t [0:WIN_SIZE-1]            win_t;

endpackage

// File: rtl/line_buffer.sv
// line_buffer: one image row of storage. Reads return the contents as they were
// before this cycle's write, so a row can be shifted into the next buffer in place.
module line_buffer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

  assign o_rdata = r_mem[i_addr];

  // Write the new pixel at the current column; contents are never cleared.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

endmodule

// File: rtl/conv_window_gen.sv
// conv_window_gen: streaming 3x3 window generator for conv2d_core.
// Define CONV_WINDOW_STRIDE2_EN to emit windows only at even row/col positions.
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned IMG_WIDTH  = 32,
  parameter int unsigned IMG_HEIGHT = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] pix_in,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  output logic [DATA_WIDTH-1:0] win_out [0:WIN_SIZE-1],
  output logic                  win_valid,
  input  logic                  win_ready,
  output logic                  frame_done
);

  localparam int unsigned ColW = $clog2(IMG_WIDTH);
  localparam int unsigned RowW = $clog2(IMG_HEIGHT);

  localparam logic [ColW-1:0] ColLast  = ColW'(IMG_WIDTH - 1);
  localparam logic [RowW-1:0] RowLast  = RowW'(IMG_HEIGHT - 1);
  localparam logic [ColW-1:0] ColFirst = ColW'(2);
  localparam logic [RowW-1:0] RowFirst = RowW'(2);

  logic [ColW-1:0]       r_col;
  logic [RowW-1:0]       r_row;
  logic [DATA_WIDTH-1:0] r_shift [0:WIN_SIZE-1];
  logic [DATA_WIDTH-1:0] r_win   [0:WIN_SIZE-1];
  logic                  r_win_valid;
  logic                  r_frame_done;

  logic                  w_accept;
  logic                  w_last;
  logic                  w_pos_ok;
  logic                  w_emit;
  logic [DATA_WIDTH-1:0] w_lb_a_rd;
  logic [DATA_WIDTH-1:0] w_lb_b_rd;
  logic [DATA_WIDTH-1:0] w_win_next [0:WIN_SIZE-1];

  assign pix_ready  = !r_win_valid || win_ready;
  assign w_accept   = pix_valid && pix_ready;
  assign w_last     = (r_row == RowLast) && (r_col == ColLast);
  assign win_out    = r_win;
  assign win_valid  = r_win_valid;
  assign frame_done = r_frame_done;

  // lb_a holds row r-1; its old contents age into lb_b (row r-2).
  line_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (IMG_WIDTH),
    .ADDR_WIDTH (ColW)
  ) u_lb_a (
    .clk     (clk),
    .i_we    (w_accept),
    .i_addr  (r_col),
    .i_wdata (pix_in),
    .o_rdata (w_lb_a_rd)
  );

  line_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (IMG_WIDTH),
    .ADDR_WIDTH (ColW)
  ) u_lb_b (
    .clk     (clk),
    .i_we    (w_accept),
    .i_addr  (r_col),
    .i_wdata (w_lb_a_rd),
    .o_rdata (w_lb_b_rd)
  );

  // Shift the window one column left and insert the new column at 2/5/8.
  always_comb begin
    w_win_next = r_shift;
    for (int i = 0; i < 3; i++) begin
      w_win_next[3*i]   = r_shift[3*i+1];
      w_win_next[3*i+1] = r_shift[3*i+2];
    end
    w_win_next[2] = w_lb_b_rd;
    w_win_next[5] = w_lb_a_rd;
    w_win_next[8] = pix_in;
  end

  // Only positions whose 3x3 neighbourhood lies fully inside the frame emit;
  // this also hides stale columns from the previous row while col < 2.
`ifdef CONV_WINDOW_STRIDE2_EN
  assign w_pos_ok = (r_row >= RowFirst) && (r_col >= ColFirst) && !r_row[0] && !r_col[0];
`else
  assign w_pos_ok = (r_row >= RowFirst) && (r_col >= ColFirst);
`endif
  assign w_emit = w_accept && w_pos_ok;

  // Raster position counters and the end-of-frame pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_col        <= '0;
      r_row        <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_accept && w_last;
      if (w_accept) begin
        if (r_col == ColLast) begin
          r_col <= '0;
          r_row <= (r_row == RowLast) ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

  // Window shift register plus the one-deep output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_win_valid <= 1'b0;
      for (int i = 0; i < WIN_SIZE; i++) begin
        r_shift[i] <= '0;
        r_win[i]   <= '0;
      end
    end else begin
      if (w_accept) begin
        r_shift <= w_win_next;
      end
      if (w_emit) begin
        r_win_valid <= 1'b1;
        r_win       <= w_win_next;
      end else if (r_win_valid && win_ready) begin
        r_win_valid <= 1'b0;
      end
    end
  end

endmodule
